// File: rtl/pipes_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   - Stage bit positions for the 5-bit stall/flush vectors ({W,M,E,D,F}).
//   - MDU timer and redirect FSM state encodings.
//   - Hazard cause encoding used to select the stall/flush response.
//   - stages_through(): mask with every stage from F up to a given stage set.
package pipes_pkg;

  localparam int NUM_STAGES = 5;
  localparam int STG_F      = 0;
  localparam int STG_D      = 1;
  localparam int STG_E      = 2;
  localparam int STG_M      = 3;
  localparam int STG_W      = 4;

  // Width of the MDU latency counter; latencies are 1..255.
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mdu_state_t;

  typedef enum logic {
    R_IDLE,
    R_WAIT
  } redir_state_t;

  // Winning hazard cause for the current cycle, highest priority first.
  typedef enum logic [2:0] {
    C_NONE,
    C_MEM,        // data request outstanding
    C_MDU,        // multiply/divide in progress
    C_LOAD_USE,   // decode reads the register a load in execute writes
    C_REDIRECT,   // branch/jump redirect acted on
    C_WAIT_FETCH, // stale fetch after redirect still outstanding
    C_DISCARD,    // stale fetch returned this cycle; drop it
    C_FETCH       // ordinary fetch wait
  } cause_t;

  // Hold mask covering F up to and including stage 'last'.
  function automatic logic [NUM_STAGES-1:0] stages_through(int last);
    logic [NUM_STAGES-1:0] mask;
    mask = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      mask[i] = (i <= last);
    end
    return mask;
  endfunction

endpackage

// File: rtl/mdu_timer.sv
// Multiply/divide latency timer.
//   clk, reset : clock, asynchronous active-low reset
//   start      : execute-stage op is mul/div
//   div        : op is a divide (selects DIV_LAT instead of MUL_LAT)
//   hold       : memory stall; freezes the countdown and blocks a start
//   busy       : operation still in progress (execute must hold)
//   done       : one-cycle pulse, result valid in execute
// A start in IDLE loads LAT-1; BUSY counts down to zero, then DONE lasts
// exactly one cycle. The counter only reloads from IDLE, so it never wraps.
module mdu_timer
  import pipes_pkg::*;
#(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic div,
  input  logic hold,
  output logic busy,
  output logic done
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

  mdu_state_t       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [CNT_W-1:0] load;

  assign load = div ? DIV_LOAD : MUL_LOAD;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (start && !hold) begin
          cnt_nx   = load;
          state_nx = (load == '0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        // Counter is at least 1 here; reaching zero ends the operation.
        if (!hold && (cnt != '0)) begin
          cnt_nx = cnt - 1'b1;
          if (cnt == CNT_W'(1)) state_nx = DONE;
        end
      end
      DONE: begin
        // A start seen here belongs to the op that just finished.
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == BUSY);
    done = (state == DONE);
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller for a 5-stage pipe (F, D, E, M, W).
//   clk, reset        : clock, asynchronous active-low reset
//   ireq_busy         : fetch request outstanding
//   dreq_busy         : memory-stage data request outstanding
//   d_rs1, d_rs2      : decode-stage source register indices
//   e_rd, e_memread   : execute-stage destination and load flag
//   e_redirect        : branch/jump redirect resolved in execute
//   e_mdu_start/_div  : execute-stage mul/div op, divide select
//   stall[4:0]        : hold enables {W,M,E,D,F}
//   flush[4:0]        : bubble inserts {W,M,E,D,F}
//   mdu_done          : one-cycle pulse, mul/div result valid
//   redirect_pending  : stale fetch from before a redirect still to discard
// stall/flush are purely combinational from inputs and current state.
module pipe_ctrl
  import pipes_pkg::*;
#(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ireq_busy,
  input  logic       dreq_busy,
  input  logic [4:0] d_rs1,
  input  logic [4:0] d_rs2,
  input  logic [4:0] e_rd,
  input  logic       e_memread,
  input  logic       e_redirect,
  input  logic       e_mdu_start,
  input  logic       e_mdu_div,
  output logic [4:0] stall,
  output logic [4:0] flush,
  output logic       mdu_done,
  output logic       redirect_pending
);

  logic         mdu_busy;
  logic         load_use;
  cause_t       cause;
  redir_state_t r_state, r_state_nx;

  mdu_timer #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_mdu (
    .clk   (clk),
    .reset (reset),
    .start (e_mdu_start),
    .div   (e_mdu_div),
    .hold  (dreq_busy),
    .busy  (mdu_busy),
    .done  (mdu_done)
  );

  // x0 is hardwired zero, so a load targeting it never creates a hazard.
  assign load_use = e_memread && (e_rd != 5'd0) &&
                    ((e_rd == d_rs1) || (e_rd == d_rs2));

  // Priority pick. A redirect only wins when E is advancing, so it stays
  // asserted in E until no higher cause masks it.
  always_comb begin
    cause = C_NONE;
    if (dreq_busy)             cause = C_MEM;
    else if (mdu_busy)         cause = C_MDU;
    else if (load_use)         cause = C_LOAD_USE;
    else if (e_redirect)       cause = C_REDIRECT;
    else if (r_state == R_WAIT) cause = ireq_busy ? C_WAIT_FETCH : C_DISCARD;
    else if (ireq_busy)        cause = C_FETCH;
  end

  always_comb begin
    stall = '0;
    flush = '0;
    unique case (cause)
      C_MEM: begin
        stall        = stages_through(STG_M);
        flush[STG_W] = 1'b1;
      end
      C_MDU: begin
        stall        = stages_through(STG_E);
        flush[STG_M] = 1'b1;
      end
      C_LOAD_USE: begin
        stall        = stages_through(STG_D);
        flush[STG_E] = 1'b1;
      end
      C_REDIRECT: begin
        flush[STG_D] = 1'b1;
        flush[STG_E] = 1'b1;
      end
      C_WAIT_FETCH: stall[STG_F] = 1'b1;
      C_DISCARD:    flush[STG_D] = 1'b1;
      C_FETCH: begin
        stall[STG_F] = 1'b1;
        flush[STG_D] = 1'b1;
      end
      default: ;
    endcase
    // Held in reset: nothing holds, every stage loads a bubble.
    if (!reset) begin
      stall = '0;
      flush = '1;
    end
  end

  // Redirect FSM: remembers that the fetch in flight at redirect time is
  // stale. Only one discard is ever owed, so further redirects just stay.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= R_IDLE;
    else        r_state <= r_state_nx;
  end

  always_comb begin
    r_state_nx = r_state;
    unique case (r_state)
      R_IDLE:  if ((cause == C_REDIRECT) && ireq_busy) r_state_nx = R_WAIT;
      R_WAIT:  if (cause == C_DISCARD) r_state_nx = R_IDLE;
      default: r_state_nx = R_IDLE;
    endcase
  end

  always_comb begin
    redirect_pending = (r_state == R_WAIT);
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl (default MUL_LAT=3, DIV_LAT=64).
// A cycle-level model (remaining-work counter, pending-discard flag and a
// priority table of responses) is compared against the DUT every cycle;
// directed sequences with literal expectations pin the model.
module tb_pipe_ctrl;

  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic       ireq_busy, dreq_busy;
  logic [4:0] d_rs1, d_rs2, e_rd;
  logic       e_memread, e_redirect, e_mdu_start, e_mdu_div;
  logic [4:0] stall, flush;
  logic       mdu_done, redirect_pending;

  int total = 0;
  int bad   = 0;

  pipe_ctrl #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .ireq_busy        (ireq_busy),
    .dreq_busy        (dreq_busy),
    .d_rs1            (d_rs1),
    .d_rs2            (d_rs2),
    .e_rd             (e_rd),
    .e_memread        (e_memread),
    .e_redirect       (e_redirect),
    .e_mdu_start      (e_mdu_start),
    .e_mdu_div        (e_mdu_div),
    .stall            (stall),
    .flush            (flush),
    .mdu_done         (mdu_done),
    .redirect_pending (redirect_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit         m_active = 0;  // an MDU op has been accepted
  int         m_rem    = 0;  // work cycles still owed before the done cycle
  bit         r_wait   = 0;  // a stale fetch must still be discarded
  logic [4:0] es, ef;
  bit         m_busy, m_done, lu, act, disc;

  always @(negedge clk) begin
    m_busy = m_active && (m_rem > 0);
    m_done = m_active && (m_rem == 0);
    lu     = e_memread && (e_rd != 0) && (e_rd == d_rs1 || e_rd == d_rs2);
    act    = 0;
    disc   = 0;
    if (!reset)               begin es = 5'b00000; ef = 5'b11111; end
    else if (dreq_busy)       begin es = 5'b01111; ef = 5'b10000; end
    else if (m_busy)          begin es = 5'b00111; ef = 5'b01000; end
    else if (lu)              begin es = 5'b00011; ef = 5'b00100; end
    else if (e_redirect)      begin es = 5'b00000; ef = 5'b00110; act = 1; end
    else if (r_wait) begin
      if (ireq_busy)          begin es = 5'b00001; ef = 5'b00000; end
      else                    begin es = 5'b00000; ef = 5'b00010; disc = 1; end
    end
    else if (ireq_busy)       begin es = 5'b00001; ef = 5'b00010; end
    else                      begin es = 5'b00000; ef = 5'b00000; end

    check("cmp_stall", stall, es);
    check("cmp_flush", flush, ef);
    check("cmp_mdu_done", mdu_done, reset ? m_done : 1'b0);
    check("cmp_pending", redirect_pending, reset ? r_wait : 1'b0);

    // advance the model to the state after the coming rising edge
    if (!reset) begin
      m_active = 0;
      m_rem    = 0;
      r_wait   = 0;
    end else begin
      if (m_done) m_active = 0;
      else if (m_busy) begin
        if (!dreq_busy) m_rem--;
      end else if (e_mdu_start && !dreq_busy) begin
        m_active = 1;
        m_rem    = (e_mdu_div ? DIV_LAT : MUL_LAT) - 1;
      end
      if (act) r_wait = r_wait | ireq_busy;
      else if (disc) r_wait = 0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
    #1;
  endtask

  task automatic quiet();
    ireq_busy = 0; dreq_busy = 0; d_rs1 = 0; d_rs2 = 0; e_rd = 0;
    e_memread = 0; e_redirect = 0; e_mdu_start = 0; e_mdu_div = 0;
  endtask

  initial begin
    int n, cyc;
    bit got, seen;
    quiet();
    reset = 1'b0;
    #2;
    check("rst_stall", stall, 5'b00000);
    check("rst_flush", flush, 5'b11111);
    check("rst_done", mdu_done, 1'b0);
    check("rst_pending", redirect_pending, 1'b0);
    step(); step();
    reset = 1'b1;
    look();
    check("idle_stall", stall, 5'b00000);
    check("idle_flush", flush, 5'b00000);

    // load-use on x5, then destination x0
    step(); e_memread = 1; e_rd = 5; d_rs1 = 5;
    look();
    check("lu_stall", stall, 5'b00011);
    check("lu_flush", flush, 5'b00100);
    step(); e_rd = 0; d_rs1 = 0;
    look();
    check("lu_x0_stall", stall, 5'b00000);
    step(); quiet();

    // divide: 63 held cycles, done on the 64th
    e_mdu_start = 1; e_mdu_div = 1;
    look();
    check("div_start_stall", stall, 5'b00000);
    step(); e_mdu_start = 0; e_mdu_div = 0;
    n = 0; got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      look();
      if (mdu_done) got = 1;
      else begin
        if (stall == 5'b00111) n++;
        step();
      end
    end
    check("div_done_seen", got, 1'b1);
    check("div_held_cycles", n, 63);
    step();
    look();
    check("div_after_stall", stall, 5'b00000);
    check("div_after_done", mdu_done, 1'b0);

    // multiply with a 3-cycle memory stall: done moves from cycle 3 to 6
    step(); e_mdu_start = 1;
    for (int i = 0; i < 3; i++) begin
      step(); e_mdu_start = 0; dreq_busy = 1;
      look();
      check("mul_mem_stall", stall, 5'b01111);
      check("mul_mem_flush", flush, 5'b10000);
    end
    step(); dreq_busy = 0;
    cyc = 4; got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      look();
      if (mdu_done) got = 1;
      else begin cyc++; step(); end
    end
    check("mul_done_cycle", cyc, 6);
    step();

    // redirect while fetch outstanding for 4 cycles
    step(); e_redirect = 1; ireq_busy = 1;
    look();
    check("rd_flush", flush, 5'b00110);
    check("rd_pending0", redirect_pending, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(); e_redirect = 0;
      look();
      check("rd_wait_pending", redirect_pending, 1'b1);
      check("rd_wait_stall", stall, 5'b00001);
      check("rd_wait_flush", flush, 5'b00000);
    end
    step(); ireq_busy = 0;
    look();
    check("rd_discard_flush", flush, 5'b00010);
    check("rd_discard_pending", redirect_pending, 1'b1);
    step();
    look();
    check("rd_end_pending", redirect_pending, 1'b0);
    check("rd_end_flush", flush, 5'b00000);

    // load-use and redirect together: load-use first, redirect next cycle
    step(); e_memread = 1; e_rd = 7; d_rs2 = 7; e_redirect = 1;
    look();
    check("lurd_stall", stall, 5'b00011);
    check("lurd_flush", flush, 5'b00100);
    step(); e_memread = 0; e_rd = 0; d_rs2 = 0;
    look();
    check("lurd_next_stall", stall, 5'b00000);
    check("lurd_next_flush", flush, 5'b00110);
    step(); quiet();

    // reset with the divide counter at 20
    e_mdu_start = 1; e_mdu_div = 1;
    step(); e_mdu_start = 0; e_mdu_div = 0;
    for (int i = 0; i < 43; i++) step();
    reset = 1'b0;
    #1;
    check("mid_rst_stall", stall, 5'b00000);
    check("mid_rst_flush", flush, 5'b11111);
    check("mid_rst_done", mdu_done, 1'b0);
    step(); step();
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 70; i++) begin
      look();
      if (mdu_done) seen = 1;
      step();
    end
    check("mid_rst_no_done", seen, 1'b0);

    // randomized traffic, checked by the model every cycle
    for (int i = 0; i < 4000; i++) begin
      reset       = ($urandom_range(0, 399) != 0);
      dreq_busy   = ($urandom_range(0, 7) == 0);
      ireq_busy   = ($urandom_range(0, 3) == 0);
      e_redirect  = ($urandom_range(0, 7) == 0);
      e_mdu_start = ($urandom_range(0, 9) == 0);
      e_mdu_div   = ($urandom_range(0, 5) == 0);
      e_memread   = ($urandom_range(0, 3) == 0);
      e_rd        = 5'($urandom_range(0, 3));
      d_rs1       = 5'($urandom_range(0, 3));
      d_rs2       = 5'($urandom_range(0, 3));
      step();
    end
    reset = 1'b1;
    quiet();
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter MUL_LAT, default 3, multiply latency in cycles (range 1..255).
REQ-002 Parameter DIV_LAT, default 64, divide latency in cycles (range 1..255).
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 ireq_busy  in  1  fetch request outstanding (no data_ok yet).
REQ-006 dreq_busy  in  1  memory-stage data request outstanding.
REQ-007 d_rs1, d_rs2  in  5 each  decode-stage source register indices.
REQ-008 e_rd  in  5  execute-stage destination index; e_memread  in  1  execute-stage op is a load.
REQ-009 e_redirect  in  1  branch/jump redirect resolved in execute.
REQ-010 e_mdu_start  in  1  execute-stage op is mul/div; e_mdu_div  in  1  op is divide.
REQ-011 stall  out  5  hold enables, bit order {W,M,E,D,F}; 1 = register keeps value.
REQ-012 flush  out  5  bubble inserts, bit order {W,M,E,D,F}; 1 = register loads all-zero.
REQ-013 mdu_done  out  1  one-cycle pulse: mul/div result valid in execute.
REQ-014 redirect_pending  out  1  redirect taken while fetch outstanding; stale fetch to be discarded.

Function
REQ-015 Stall/flush SHALL be combinational from inputs and current state; no latency.
REQ-016 Priority SHALL be: memory stall > MDU busy > load-use > redirect > stale-fetch discard.
REQ-017 Memory stall (dreq_busy=1): stall F,D,E,M; flush W; all lower causes masked.
REQ-018 MDU busy (state BUSY): stall F,D,E; flush M.
REQ-019 Load-use: e_memread=1, e_rd!=0, e_rd equals d_rs1 or d_rs2 -> stall F,D; flush E.
REQ-020 Redirect: e_redirect=1 and E advancing -> flush D and E; never asserted while a higher cause is active (E is held, so e_redirect persists until acted on).
REQ-021 Fetch stall: ireq_busy=1 with no higher cause -> stall F only, flush D.
REQ-022 MDU FSM states IDLE, BUSY, DONE.
REQ-023 IDLE -> BUSY when e_mdu_start=1 and dreq_busy=0; counter loads (e_mdu_div ? DIV_LAT : MUL_LAT) - 1; if that value is 0, IDLE -> DONE directly.
REQ-024 BUSY: counter decrements each cycle dreq_busy=0, holds when dreq_busy=1; at counter 0 -> DONE.
REQ-025 DONE: mdu_done=1 for exactly one cycle, e_mdu_start ignored, -> IDLE; E not stalled by MDU in DONE.
REQ-026 Back-to-back mul/div: the second op starts from IDLE the cycle after DONE.
REQ-027 Counter width SHALL be 8 bits; no wrap-around permitted (reload only from IDLE).
REQ-028 Redirect FSM states R_IDLE, R_WAIT; R_IDLE -> R_WAIT when redirect acted on (REQ-020) and ireq_busy=1.
REQ-029 R_WAIT: redirect_pending=1; stall F while ireq_busy=1; on ireq_busy=0 flush D for that cycle (discard stale instruction) and -> R_IDLE.
REQ-030 A new redirect in R_WAIT SHALL keep R_WAIT (single pending discard, no count).
REQ-031 Register index 0 SHALL never create a load-use hazard.

Reset
REQ-032 reset=0 asynchronously forces IDLE, R_IDLE, counter=0, mdu_done=0, redirect_pending=0.
REQ-033 During reset stall=5'b0, flush=5'b11111; reset mid-MDU or mid-R_WAIT abandons the operation with no done pulse.

Structure
REQ-034 stall/flush bit-index constants, mdu_state_t and redir_state_t enums SHALL live in the shared pipes package.
REQ-035 One sub-module mdu_timer SHALL hold the MDU FSM and counter; pipe_ctrl holds hazard logic and redirect FSM.

Verification
REQ-036 Load x5, d_rs1=5 -> stall=00011, flush=00100 one cycle; e_rd=0 -> no stall.
REQ-037 Divide start, DIV_LAT=64 -> stall=00111 for 63 cycles, mdu_done on 64th, then stall=0.
REQ-038 dreq_busy=1 for 3 cycles during MUL (MUL_LAT=3) -> stall=01111, flush=10000; mdu_done delayed exactly 3 cycles.
REQ-039 e_redirect with ireq_busy=1 for 4 cycles -> flush=00110 once, redirect_pending 4 cycles, then flush=00010 once.
REQ-040 Load-use and redirect same cycle -> load-use response only; redirect acted on next cycle.
REQ-041 reset=0 asserted mid-divide (counter 20) -> immediate IDLE, no mdu_done; resumes normal after release.
